// File: rtl/fc5_pkg.sv
// Shared constants, FSM encoding and requantisation for the F5 (400 -> 120) layer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fc5_pkg;

    localparam int N_IN   = 400;  // inputs per neuron = address sweep length
    localparam int N_OUT  = 120;  // parallel neurons / weight ROM lanes
    localparam int DW     = 8;    // feature, weight and output width
    localparam int ACC_W  = 25;   // 16-bit product + 9 guard bits for 400 terms
    localparam int SHIFT  = 7;    // requantisation arithmetic right shift
    localparam int ADDR_W = 9;
    localparam int IDX_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fc5_state_e;

    // Arithmetic shift, clamp negatives to zero, saturate to the positive
    // range of a DW-bit signed word (0..127).
    function automatic logic [DW-1:0] requant(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        logic [DW-1:0]           res;
        sh = acc >>> SHIFT;
        if (sh[ACC_W-1]) begin
            res = '0;
        end else if (|sh[ACC_W-2:DW-1]) begin
            res = {1'b0, {(DW-1){1'b1}}};
        end else begin
            res = sh[DW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fc5_mac_array_if.sv
// Result stream from the F5 engine to the F6 input buffer.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_data/out_idx held by the master until out_ready.
// Modports: master = F5 engine (drives valid/idx/data), slave = F6 buffer (drives ready).
interface fc5_mac_array_if;
    import fc5_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [DW-1:0]    out_data;

    modport master (
        output out_valid,
        output out_idx,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/fc5_mac_lane.sv
// One signed multiply-accumulate lane with synchronous clear and enable.
// Latency: acc shows the running sum including the current product combinationally; state updates next edge.
// Backpressure: none (enable-driven).
// Ports: clk, rst_n; clr (zero the sum), en (absorb feat*wt), feat/wt (signed DW), acc (signed ACC_W).
module fc5_mac_lane
    import fc5_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [DW-1:0]           feat,
    input  logic [DW-1:0]           wt,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;

    assign prod     = $signed(feat) * $signed(wt);
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    // Exposing the next value lets the top requantise lane 0 on the same
    // edge that absorbs the final product, saving a cycle of latency.
    // When en is low this is simply the stored sum.
    assign acc = en ? (acc_q + prod_ext) : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc;
        end
    end

endmodule

// File: rtl/fc5_mac_array.sv
// F5 fully-connected engine: 400-step address sweep, 120 parallel MACs, requantised in-order output stream.
// Latency: start accepted at cycle T -> first out_valid at T+402; done 1 cycle after handshake of idx 119.
// Backpressure: out_ready low holds out_idx/out_data/out_valid unchanged; nothing is dropped.
// Ports: clk, rst_n; start/busy/done control; fc_raddr -> feat_rdata/w5_rdata (1-cycle read);
//        out_bus (master) carries out_valid/out_ready/out_idx/out_data.
module fc5_mac_array
    import fc5_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     fc_raddr,
    input  logic [DW-1:0]         feat_rdata,
    input  logic [N_OUT*DW-1:0]   w5_rdata,
    fc5_mac_array_if.master       out_bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_OUT - 1);

    fc5_state_e state, state_nxt;

    logic                    mac_vld;
    logic                    acc_clr;
    logic                    hs;
    logic [IDX_W-1:0]        rd_idx;
    logic [DW-1:0]           rq_data;
    logic signed [ACC_W-1:0] lane_acc [N_OUT];

    assign busy    = (state != ST_IDLE);
    assign acc_clr = (state == ST_IDLE) && start;
    assign hs      = out_bus.out_valid && out_bus.out_ready;

    // ------------------------------------------------------------------
    // MAC lanes
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_lane
            fc5_mac_lane u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (acc_clr),
                .en    (mac_vld),
                .feat  (feat_rdata),
                .wt    (w5_rdata[g*DW +: DW]),
                .acc   (lane_acc[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output mux: in DRAIN preload neuron 0 (its lane value already
    // includes the last product); in OUT prefetch the next neuron so it is
    // ready on the handshake edge. Index is kept in range after idx 119.
    // ------------------------------------------------------------------
    always_comb begin
        rd_idx = '0;
        if (state == ST_OUT && out_bus.out_idx != LAST_IDX) begin
            rd_idx = out_bus.out_idx + 1'b1;
        end
    end

    assign rq_data = requant(lane_acc[rd_idx]);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (fc_raddr == LAST_ADDR) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_OUT;
            // The done pulse is emitted while still in OUT (out_valid already
            // low), so a start coinciding with done is not accepted.
            ST_OUT:   if (!out_bus.out_valid) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address counter, read-latency flag, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_raddr          <= '0;
            mac_vld           <= 1'b0;
            done              <= 1'b0;
            out_bus.out_valid <= 1'b0;
            out_bus.out_idx   <= '0;
            out_bus.out_data  <= '0;
        end else begin
            done    <= 1'b0;
            // Read data returns one cycle after the address phase.
            mac_vld <= (state == ST_RUN);

            case (state)
                ST_RUN: begin
                    if (fc_raddr == LAST_ADDR) begin
                        fc_raddr <= '0;
                    end else begin
                        fc_raddr <= fc_raddr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    fc_raddr          <= '0;
                    out_bus.out_valid <= 1'b1;
                    out_bus.out_idx   <= '0;
                    out_bus.out_data  <= rq_data;
                end
                ST_OUT: begin
                    if (hs) begin
                        if (out_bus.out_idx == LAST_IDX) begin
                            out_bus.out_valid <= 1'b0;
                            done              <= 1'b1;
                        end else begin
                            out_bus.out_idx  <= rd_idx;
                            out_bus.out_data <= rq_data;
                        end
                    end
                end
                default: begin
                    fc_raddr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc5_mac_array.sv
// Self-checking bench for fc5_mac_array: memory responder, integer reference model, scoreboard monitor.
// Latency: checks first out_valid at T+402 and done at T+522 with out_ready held high.
// Backpressure: out_ready held high, randomised, or held low for 50 cycles mid-stream.
module tb_fc5_mac_array;
    import fc5_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   fc_raddr;
    logic [DW-1:0]       feat_rdata = '0;
    logic [N_OUT*DW-1:0] w5_rdata = '0;

    fc5_mac_array_if ob ();

    fc5_mac_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fc_raddr   (fc_raddr),
        .feat_rdata (feat_rdata),
        .w5_rdata   (w5_rdata),
        .out_bus    (ob)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- memories with 1-cycle read latency ----------------
    logic signed [7:0] fmem [N_IN];
    logic signed [7:0] wmem [N_OUT][N_IN];

    always @(posedge clk) begin
        int a;
        a = int'(fc_raddr);
        feat_rdata <= (a < N_IN) ? fmem[a] : 8'h00;
        for (int i = 0; i < N_OUT; i++)
            w5_rdata[i*DW +: DW] <= (a < N_IN) ? wmem[i][a] : 8'h00;
    end

    task automatic load(input int mode);
        for (int k = 0; k < N_IN; k++) begin
            case (mode)
                0: fmem[k] = 8'sd1;
                1, 2: fmem[k] = 8'sd127;
                3: fmem[k] = 8'sd2;
                default: fmem[k] = 8'($urandom_range(0, 127) - 64);
            endcase
            for (int i = 0; i < N_OUT; i++) begin
                case (mode)
                    0: wmem[i][k] = 8'sd1;
                    1: wmem[i][k] = 8'sd127;
                    2: wmem[i][k] = -8'sd128;
                    3: wmem[i][k] = 8'(i - 60);
                    default: wmem[i][k] = 8'($urandom_range(0, 31) - 16);
                endcase
            end
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int exp_q[$];

    task automatic push_expected();
        for (int i = 0; i < N_OUT; i++) begin
            int s;
            int q;
            s = 0;
            for (int k = 0; k < N_IN; k++) s += int'(fmem[k]) * int'(wmem[i][k]);
            q = s >>> SHIFT;
            if (q < 0) q = 0;
            if (q > 127) q = 127;
            exp_q.push_back((i << 8) | q);
        end
    endtask

    int   last_idx = -1;
    int   done_cnt = 0;
    bit   prev_stall = 1'b0;
    logic [IDX_W-1:0] st_idx;
    logic [DW-1:0]    st_dat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", ob.out_valid, 1);
                check("stall_idx", ob.out_idx, st_idx);
                check("stall_data", ob.out_data, st_dat);
            end
            prev_stall = ob.out_valid && !ob.out_ready;
            st_idx = ob.out_idx;
            st_dat = ob.out_data;
            if (ob.out_valid && ob.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", ob.out_idx, -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("out_idx", ob.out_idx, e >> 8);
                    check("out_data", ob.out_data, e & 255);
                    last_idx = int'(ob.out_idx);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_after_last", last_idx, N_OUT - 1);
                check("done_queue_empty", exp_q.size(), 0);
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int ready_mode = 0;
    int hold = 0;
    bit held = 1'b0;

    initial begin
        ob.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: ob.out_ready = 1'b1;
                1: ob.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!held && ob.out_valid && ob.out_idx == 7'd60) begin
                        held = 1'b1;
                        hold = 50;
                    end
                    if (hold > 0) begin
                        hold--;
                        ob.out_ready = 1'b0;
                    end else begin
                        ob.out_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            endcase
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_raddr"}, fc_raddr, 0);
        check({tag, "_valid"}, ob.out_valid, 0);
        check({tag, "_idx"}, ob.out_idx, 0);
        check({tag, "_data"}, ob.out_data, 0);
    endtask

    // One run; cycle numbers are counted from the start cycle T (cyc=0).
    task automatic do_run(input int rmode, input bit poke, input bit abort);
        int addr_err;
        int cyc;
        int waitc;
        int done_cyc;
        ready_mode = rmode;
        held = 1'b0;
        hold = 0;
        done_cnt = 0;
        if (!abort) push_expected();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        addr_err = 0;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(fc_raddr) != k) addr_err++;
            if (abort && k == 200) begin
                rst_n = 1'b0;
                #1;
                check_reset_values("abort_reset");
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            start = poke && (k == 100);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("addr_seq_errors", addr_err, 0);
        check("drain_valid_low", ob.out_valid, 0);
        check("drain_raddr_parked", fc_raddr, 0);
        @(posedge clk);
        #1;
        cyc = 402;
        check("first_valid_at_T402", ob.out_valid, 1);
        waitc = 0;
        done_cyc = -1;
        while (busy && waitc < 5000) begin
            start = poke && ((cyc == 410) || (done == 1'b1));
            if (done && done_cyc < 0) done_cyc = cyc;
            @(posedge clk);
            #1;
            cyc++;
            waitc++;
        end
        start = 1'b0;
        check("run_timeout", waitc >= 5000, 0);
        if (rmode == 0) check("done_at_T522", done_cyc, 522);
        @(posedge clk);
        #1;
        check("idle_after_done", busy, 0);
        check("done_count", done_cnt, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        load(0); do_run(0, 1'b0, 1'b0);  // every out_data = 3
        load(1); do_run(1, 1'b0, 1'b0);  // saturate to 127
        load(2); do_run(0, 1'b0, 1'b0);  // ReLU to 0
        load(3); do_run(2, 1'b0, 1'b0);  // lane ramp, 50-cycle stall
        load(4); do_run(1, 1'b1, 1'b0);  // random, start pokes in RUN/OUT/done
        load(4); do_run(0, 1'b0, 1'b0);  // back-to-back, new data
        load(4); do_run(0, 1'b0, 1'b1);  // reset at address 200
        check("post_abort_no_output", last_idx, N_OUT - 1);
        load(3); do_run(0, 1'b0, 1'b0);  // fresh run after reset

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
